// File: rtl/scale_and_mul_pipe.sv
// Scale-add / fraction-multiply core for decoded posits, with an elastic
// valid/ready pipeline of STAGES registers and optional [1,2) normalisation.
module scale_and_mul_pipe #(
  parameter int SCALE_W = 4,
  parameter int FRAC_W  = 6,
  parameter int STAGES  = 2,
  parameter int NORM    = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [SCALE_W-1:0]    SCALE_A,
  input  logic [SCALE_W-1:0]    SCALE_B,
  input  logic [FRAC_W-1:0]     FRAC_A,
  input  logic [FRAC_W-1:0]     FRAC_B,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [SCALE_W:0]      SCALE_C,
  output logic [2*FRAC_W-1:0]   FRAC_C,
  output logic                  STICKY
);

  localparam int SW = SCALE_W + 1;
  localparam int PW = 2 * FRAC_W;

  logic [SW-1:0]     sum_in;
  logic [PW-1:0]     prod_in;

  logic [STAGES-1:0] vld_q, vld_d;
  logic [STAGES-1:0] en;
  logic [STAGES-1:0] src_vld;
  logic [SW-1:0]     src_scale [STAGES];
  logic [PW-1:0]     src_frac  [STAGES];

  logic [SW-1:0]     scale_q  [STAGES];
  logic [SW-1:0]     scale_d  [STAGES];
  logic [PW-1:0]     frac_q   [STAGES];
  logic [PW-1:0]     frac_d   [STAGES];
  logic [STAGES-1:0] sticky_q, sticky_d;

  always_comb begin
    sum_in  = {SCALE_A[SCALE_W-1], SCALE_A} + {SCALE_B[SCALE_W-1], SCALE_B};
    prod_in = PW'(FRAC_A) * PW'(FRAC_B);
  end

  // A stage may load when it, or any stage after it, has a hole, or the
  // consumer is taking the head; accumulating into a local keeps this acyclic.
  always_comb begin
    logic acc;
    acc = OUT_READY;
    en  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc   = acc | ~vld_q[k];
      en[k] = acc;
    end
  end

  always_comb begin
    src_vld      = '0;
    src_vld[0]   = IN_VALID;
    src_scale[0] = sum_in;
    src_frac[0]  = prod_in;
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k]   = vld_q[k-1];
      src_scale[k] = scale_q[k-1];
      src_frac[k]  = frac_q[k-1];
    end
  end

  // Normalisation happens on entry to the last stage so it shares a cycle
  // with nothing but a register-to-register move when STAGES > 1.
  always_comb begin
    logic [SW-1:0] ld_scale;
    logic [PW-1:0] ld_frac;
    logic          ld_sticky;
    ld_scale  = '0;
    ld_frac   = '0;
    ld_sticky = 1'b0;
    vld_d     = vld_q;
    sticky_d  = sticky_q;
    for (int k = 0; k < STAGES; k++) begin
      ld_scale  = src_scale[k];
      ld_frac   = src_frac[k];
      ld_sticky = 1'b0;
      if ((k == STAGES - 1) && (NORM != 0) && ld_frac[PW-1]) begin
        ld_sticky = ld_frac[0];
        ld_frac   = ld_frac >> 1;
        ld_scale  = ld_scale + SW'(1);
      end

      vld_d[k]   = en[k] ? src_vld[k] : vld_q[k];
      scale_d[k] = scale_q[k];
      frac_d[k]  = frac_q[k];
      if (en[k] && src_vld[k]) begin
        scale_d[k]  = ld_scale;
        frac_d[k]   = ld_frac;
        sticky_d[k] = ld_sticky;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      vld_q    <= '0;
      sticky_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        scale_q[k] <= '0;
        frac_q[k]  <= '0;
      end
    end else begin
      vld_q    <= vld_d;
      sticky_q <= sticky_d;
      for (int k = 0; k < STAGES; k++) begin
        scale_q[k] <= scale_d[k];
        frac_q[k]  <= frac_d[k];
      end
    end
  end

  always_comb begin
    IN_READY  = en[0];
    OUT_VALID = vld_q[STAGES-1];
    SCALE_C   = scale_q[STAGES-1];
    FRAC_C    = frac_q[STAGES-1];
    STICKY    = sticky_q[STAGES-1];
  end

endmodule

// File: tb/tb_scale_and_mul_pipe.sv
// Directed bench for scale_and_mul_pipe: main config (2 stages, normalised)
// plus raw-product, 1-stage and 4-stage instances sharing the same stimulus.
module tb_scale_and_mul_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [3:0]  scale_a, scale_b;
  logic [5:0]  frac_a, frac_b;

  logic        ir_m, ov_m, st_m;
  logic [4:0]  sc_m;
  logic [11:0] fc_m;
  logic        ir_r, ov_r, st_r;
  logic [4:0]  sc_r;
  logic [11:0] fc_r;
  logic        ir_1, ov_1, st_1;
  logic [4:0]  sc_1;
  logic [11:0] fc_1;
  logic        ir_4, ov_4, st_4;
  logic [4:0]  sc_4;
  logic [11:0] fc_4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  scale_and_mul_pipe #(.SCALE_W(4), .FRAC_W(6), .STAGES(2), .NORM(1)) u_main (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(ir_m),
    .SCALE_A(scale_a), .SCALE_B(scale_b), .FRAC_A(frac_a), .FRAC_B(frac_b),
    .OUT_VALID(ov_m), .OUT_READY(out_ready), .SCALE_C(sc_m), .FRAC_C(fc_m), .STICKY(st_m));

  scale_and_mul_pipe #(.SCALE_W(4), .FRAC_W(6), .STAGES(2), .NORM(0)) u_raw (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(ir_r),
    .SCALE_A(scale_a), .SCALE_B(scale_b), .FRAC_A(frac_a), .FRAC_B(frac_b),
    .OUT_VALID(ov_r), .OUT_READY(out_ready), .SCALE_C(sc_r), .FRAC_C(fc_r), .STICKY(st_r));

  scale_and_mul_pipe #(.SCALE_W(4), .FRAC_W(6), .STAGES(1), .NORM(1)) u_s1 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(ir_1),
    .SCALE_A(scale_a), .SCALE_B(scale_b), .FRAC_A(frac_a), .FRAC_B(frac_b),
    .OUT_VALID(ov_1), .OUT_READY(out_ready), .SCALE_C(sc_1), .FRAC_C(fc_1), .STICKY(st_1));

  scale_and_mul_pipe #(.SCALE_W(4), .FRAC_W(6), .STAGES(4), .NORM(1)) u_s4 (
    .CLK(clk), .RST_N(rst_n), .IN_VALID(in_valid), .IN_READY(ir_4),
    .SCALE_A(scale_a), .SCALE_B(scale_b), .FRAC_A(frac_a), .FRAC_B(frac_b),
    .OUT_VALID(ov_4), .OUT_READY(out_ready), .SCALE_C(sc_4), .FRAC_C(fc_4), .STICKY(st_4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Hand-computed stream vectors (NORM=1 results).
  logic [3:0]  v_sa [8] = '{4'h1, 4'h2, 4'hE, 4'h7, 4'h0, 4'h5, 4'hF, 4'h6};
  logic [3:0]  v_sb [8] = '{4'hF, 4'h3, 4'hD, 4'h8, 4'h0, 4'h4, 4'hF, 4'h1};
  logic [5:0]  v_fa [8] = '{6'h20, 6'h3F, 6'h21, 6'h28, 6'h00, 6'h2D, 6'h3B, 6'h31};
  logic [5:0]  v_fb [8] = '{6'h30, 6'h20, 6'h3F, 6'h28, 6'h3F, 6'h2D, 6'h25, 6'h2B};
  logic [4:0]  e_sc [8] = '{5'h00, 5'h05, 5'h1C, 5'h1F, 5'h00, 5'h09, 5'h1F, 5'h08};
  logic [11:0] e_fc [8] = '{12'h600, 12'h7E0, 12'h40F, 12'h640, 12'h000, 12'h7E9, 12'h443, 12'h41D};
  logic        e_st [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic        rdy_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  int lat_m, lat_r, lat_1, lat_4;
  logic [4:0]  cs_m, cs_r, cs_1, cs_4;
  logic [11:0] cf_m, cf_r, cf_1, cf_4;
  logic        ct_m, ct_r, ct_1, ct_4;

  // Single operand pair into all instances; records first-valid cycle and result.
  task automatic run_single(input logic [3:0] sa, input logic [3:0] sb,
                            input logic [5:0] fa, input logic [5:0] fb);
    @(negedge clk);
    scale_a = sa; scale_b = sb; frac_a = fa; frac_b = fb;
    in_valid = 1'b1; out_ready = 1'b1;
    lat_m = 0; lat_r = 0; lat_1 = 0; lat_4 = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) in_valid = 1'b0;
      if (lat_m == 0 && ov_m) begin lat_m = cyc; cs_m = sc_m; cf_m = fc_m; ct_m = st_m; end
      if (lat_r == 0 && ov_r) begin lat_r = cyc; cs_r = sc_r; cf_r = fc_r; ct_r = st_r; end
      if (lat_1 == 0 && ov_1) begin lat_1 = cyc; cs_1 = sc_1; cf_1 = fc_1; ct_1 = st_1; end
      if (lat_4 == 0 && ov_4) begin lat_4 = cyc; cs_4 = sc_4; cf_4 = fc_4; ct_4 = st_4; end
    end
  endtask

  initial begin
    int in_cnt, out_cnt, cyc;
    logic held_valid, stale;
    logic [4:0]  h_sc;
    logic [11:0] h_fc;
    logic        h_st;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    scale_a = '0; scale_b = '0; frac_a = '0; frac_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", ov_m, 1'b0);
    chk("rst_scale", sc_m, 5'h00);
    chk("rst_frac", fc_m, 12'h000);
    chk("rst_sticky", st_m, 1'b0);
    chk("rst_in_ready", ir_m, 1'b1);
    chk("rst_s4_valid", ov_4, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1.5 * 1.5, scales 3 + 2
    run_single(4'h3, 4'h2, 6'h30, 6'h30);
    chk("s2_latency", lat_m, 2);
    chk("s2_frac", cf_m, 12'h480);
    chk("s2_scale", cs_m, 5'd6);
    chk("s2_sticky", ct_m, 1'b0);
    chk("s1_latency", lat_1, 1);
    chk("s1_frac", cf_1, 12'h480);
    chk("s1_scale", cs_1, 5'd6);
    chk("s4_latency", lat_4, 4);
    chk("s4_frac", cf_4, 12'h480);
    chk("s4_scale", cs_4, 5'd6);
    chk("raw_frac_1p5", cf_r, 12'h900);
    chk("raw_scale_1p5", cs_r, 5'd5);

    // most negative scales, 1.0 * 1.0
    run_single(4'h8, 4'h8, 6'h20, 6'h20);
    chk("neg_frac", cf_m, 12'h400);
    chk("neg_scale", cs_m, 5'h10);
    chk("neg_sticky", ct_m, 1'b0);

    // largest fractions and scales: normalise with sticky
    run_single(4'h7, 4'h7, 6'h3F, 6'h3F);
    chk("max_frac", cf_m, 12'h7C0);
    chk("max_scale", cs_m, 5'd15);
    chk("max_sticky", ct_m, 1'b1);
    chk("max_raw_frac", cf_r, 12'hF81);
    chk("max_raw_scale", cs_r, 5'd14);
    chk("max_raw_sticky", ct_r, 1'b0);

    // Back-to-back stream with back-pressure pattern 1,0,0,1
    @(negedge clk);
    in_cnt = 0; out_cnt = 0; cyc = 0; held_valid = 1'b0;
    h_sc = '0; h_fc = '0; h_st = 1'b0;
    while (out_cnt < 8 && cyc < 200) begin
      out_ready = rdy_pat[cyc % 4];
      if (in_cnt < 8) begin
        in_valid = 1'b1;
        scale_a = v_sa[in_cnt]; scale_b = v_sb[in_cnt];
        frac_a  = v_fa[in_cnt]; frac_b  = v_fb[in_cnt];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk("stream_in_ready", ir_m, out_ready || ((in_cnt - out_cnt) < 2));
      if (held_valid) begin
        chk("stall_valid", ov_m, 1'b1);
        chk("stall_scale", sc_m, h_sc);
        chk("stall_frac", fc_m, h_fc);
        chk("stall_sticky", st_m, h_st);
      end
      held_valid = ov_m && !out_ready;
      h_sc = sc_m; h_fc = fc_m; h_st = st_m;
      if (ov_m && out_ready) begin
        chk("stream_scale", sc_m, e_sc[out_cnt]);
        chk("stream_frac", fc_m, e_fc[out_cnt]);
        chk("stream_sticky", st_m, e_st[out_cnt]);
        out_cnt++;
      end
      if (in_valid && ir_m) in_cnt++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_count", out_cnt, 8);

    // Fill under back-pressure, then reset mid-stream
    out_ready = 1'b0; in_valid = 1'b1;
    scale_a = v_sa[2]; scale_b = v_sb[2]; frac_a = v_fa[2]; frac_b = v_fb[2];
    repeat (3) @(negedge clk);
    chk("full_in_ready", ir_m, 1'b0);
    chk("full_out_valid", ov_m, 1'b1);
    rst_n = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrst_out_valid", ov_m, 1'b0);
    chk("midrst_scale", sc_m, 5'h00);
    chk("midrst_frac", fc_m, 12'h000);
    chk("midrst_sticky", st_m, 1'b0);
    chk("midrst_in_ready", ir_m, 1'b1);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      stale = stale | ov_m;
    end
    chk("no_stale_result", stale, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
